// File: rtl/stream_mux_n.sv
// Packet-aware N:1 stream mux with a registered output stage.
// Define STREAM_MUX_RR_EN for round-robin selection instead of sel.
module stream_mux_n #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SELW-1:0]       sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_nxt;

  logic [SELW-1:0]  lock_ch;
  logic [SELW-1:0]  cand;
  logic [SELW-1:0]  grant;
  logic             cand_ok;
  logic             grant_ok;
  logic             room;
  logic             xfer;
  logic             beat_last;
  logic [WIDTH-1:0] beat_data;

  assign room = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0] ptr;
  logic            unused_sel;

  assign unused_sel = ^sel;

  // Scan downward so the channel nearest the pointer wins.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (in_valid[(int'(ptr) + k) % N_CH]) begin
        cand    = SELW'((int'(ptr) + k) % N_CH);
        cand_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && beat_last) begin
      ptr <= (int'(grant) == N_CH - 1) ? '0
                                        : grant + SELW'(1);
    end
  end
`else
  assign cand    = sel;
  assign cand_ok = int'(sel) < N_CH;
`endif

  always_comb begin
    grant    = cand;
    grant_ok = cand_ok;
    if (state == LOCKED) begin
      grant    = lock_ch;
      grant_ok = 1'b1;
    end
  end

  always_comb begin
    in_ready  = '0;
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = grant_ok && room && (grant == SELW'(i));
      if (in_ready[i]) begin
        beat_data = in_data[i*WIDTH +: WIDTH];
        beat_last = in_last[i];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer && !beat_last) state_nxt = LOCKED;
      LOCKED:  if (xfer && beat_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && xfer && !beat_last) begin
        lock_ch <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_last  <= beat_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
